// File: rtl/bubble_ctrl_frontend_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bubble_ctrl_pkg
// Brief    : Shared FSM state type and access-mode codes for the Bubble
//            System control-strobe front end.
// Revision : 1.0 - initial release
// ============================================================================
package bubble_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STANDBY = 2'd1,
        ACCESS  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [2:0] MODE_NONE     = 3'b000;
    localparam logic [2:0] MODE_BOOT     = 3'b001;
    localparam logic [2:0] MODE_BOOT_REP = 3'b010;
    localparam logic [2:0] MODE_PAGE     = 3'b011;
    localparam logic [2:0] MODE_PAGE_REP = 3'b100;

    // Map the active-low boot/replicate enables onto an access class
    function automatic logic [2:0] classify(input logic i_nbooten, input logic i_nrepen);
        logic [2:0] w_mode;
        case ({i_nbooten, i_nrepen})
            2'b01:   w_mode = MODE_BOOT;
            2'b00:   w_mode = MODE_BOOT_REP;
            2'b11:   w_mode = MODE_PAGE;
            default: w_mode = MODE_PAGE_REP;
        endcase
        return w_mode;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bubble_ctrl_frontend_if.sv
`default_nettype none
// ============================================================================
// Module   : bubble_ctrl_frontend_if
// Brief    : Raw host strobes in, filtered strobes and access status out.
// Revision : 1.0 - initial release
// ============================================================================
interface bubble_ctrl_frontend_if #(
    parameter int CNT_W = 16
);
    logic             nBSS;
    logic             nBSEN;
    logic             nREPEN;
    logic             nBOOTEN;
    logic             nSWAPEN;
    logic             nBSS_F;
    logic             nBSEN_F;
    logic             nREPEN_F;
    logic             nBOOTEN_F;
    logic             nSWAPEN_F;
    logic             ACC_START;
    logic             ACC_END;
    logic             ACC_ABORT;
    logic [2:0]       ACCMODE;
    logic             BUSY;
    logic [CNT_W-1:0] ACCCNT;
    logic             ERR;

    modport master (
        output nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN,
        input  nBSS_F, nBSEN_F, nREPEN_F, nBOOTEN_F, nSWAPEN_F,
        input  ACC_START, ACC_END, ACC_ABORT, ACCMODE, BUSY, ACCCNT, ERR
    );

    modport slave (
        input  nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN,
        output nBSS_F, nBSEN_F, nREPEN_F, nBOOTEN_F, nSWAPEN_F,
        output ACC_START, ACC_END, ACC_ABORT, ACCMODE, BUSY, ACCCNT, ERR
    );
endinterface
`default_nettype wire

// File: rtl/bubble_ctrl_frontend_sig_filter.sv
`default_nettype none
// ============================================================================
// Module   : sig_filter
// Brief    : 2-FF synchroniser followed by a hold-time glitch filter. The
//            output follows a new level only after it has been stable for
//            FILT_LEN synchronised cycles.
// Revision : 1.0 - initial release
// ============================================================================
module sig_filter #(
    parameter int FILT_LEN = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_raw,
    output logic      o_filt
);
    logic       r_s1;
    logic       r_s2;
    logic       r_filt;
    logic [3:0] r_cnt;

    // Two-stage synchroniser; idles high like the strobes it carries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Count consecutive disagreeing cycles; adopt the new level on the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt <= 1'b1;
            r_cnt  <= 4'd0;
        end else if (r_s2 == r_filt) begin
            r_cnt  <= 4'd0;
        end else if (r_cnt == 4'(FILT_LEN - 1)) begin
            r_filt <= r_s2;
            r_cnt  <= 4'd0;
        end else begin
            r_cnt  <= r_cnt + 4'd1;
        end
    end

    assign o_filt = r_filt;
endmodule
`default_nettype wire

// File: rtl/bubble_ctrl_frontend.sv
`default_nettype none
// ============================================================================
// Module   : bubble_ctrl_frontend
// Brief    : Filters the Bubble System host strobes, tracks the access
//            sequence, classifies each access and reports start/end/abort,
//            a completed-access count and a sticky protocol error.
// Revision : 1.0 - initial release
// ============================================================================
import bubble_ctrl_pkg::*;

module bubble_ctrl_frontend #(
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 16
) (
    input  wire logic        MCLK,
    input  wire logic        RST,
    bubble_ctrl_frontend_if.slave bus
);
    // Strobe index: 0 nBSS, 1 nBSEN, 2 nREPEN, 3 nBOOTEN, 4 nSWAPEN
    logic [4:0]       w_raw;
    logic [4:0]       w_filt;
    logic             r_bss_d;
    logic             r_bsen_d;
    state_t           r_state;
    state_t           w_next;
    logic             w_start;
    logic             w_end;
    logic             w_abort;
    logic             w_err_set;
    logic             w_bss_fall;
    logic             w_bss_rise;
    logic             w_bsen_fall;
    logic             w_bsen_rise;
    logic             r_start;
    logic             r_end;
    logic             r_abort;
    logic [2:0]       r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    assign w_raw = {bus.nSWAPEN, bus.nBOOTEN, bus.nREPEN, bus.nBSEN, bus.nBSS};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_filt
            sig_filter #(.FILT_LEN(FILT_LEN)) u_filt (
                .clk    (MCLK),
                .rst    (RST),
                .i_raw  (w_raw[gi]),
                .o_filt (w_filt[gi])
            );
        end
    endgenerate

    // Delayed copies of the filtered select strobes for edge detection
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            r_bss_d  <= 1'b1;
            r_bsen_d <= 1'b1;
        end else begin
            r_bss_d  <= w_filt[0];
            r_bsen_d <= w_filt[1];
        end
    end

    assign w_bss_fall  =  r_bss_d  & ~w_filt[0];
    assign w_bss_rise  = ~r_bss_d  &  w_filt[0];
    assign w_bsen_fall =  r_bsen_d & ~w_filt[1];
    assign w_bsen_rise = ~r_bsen_d &  w_filt[1];

    // FSM state register
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and event strobes; a select release always wins as an abort
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_end     = 1'b0;
        w_abort   = 1'b0;
        w_err_set = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_bsen_fall && w_filt[0]) begin
                    w_next    = FAULT;
                    w_err_set = 1'b1;
                end else if (w_bss_fall) begin
                    w_next = STANDBY;
                end
            end
            STANDBY: begin
                if (w_bss_rise) begin
                    w_next = IDLE;
                end else if (w_bsen_fall) begin
                    w_next  = ACCESS;
                    w_start = 1'b1;
                end
            end
            ACCESS: begin
                if (w_bss_rise) begin
                    w_next    = IDLE;
                    w_abort   = 1'b1;
                    w_err_set = 1'b1;
                end else if (w_bsen_rise) begin
                    w_next = STANDBY;
                    w_end  = 1'b1;
                end
            end
            FAULT: begin
                if (w_filt[1]) begin
                    w_next = w_filt[0] ? IDLE : STANDBY;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Registered pulses, access class, completion counter and sticky error
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            r_start <= 1'b0;
            r_end   <= 1'b0;
            r_abort <= 1'b0;
            r_mode  <= MODE_NONE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_start <= w_start;
            r_end   <= w_end;
            r_abort <= w_abort;
            if (w_start) begin
                r_mode <= classify(w_filt[3], w_filt[2]);
            end
            if (w_end) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.nBSS_F    = w_filt[0];
    assign bus.nBSEN_F   = w_filt[1];
    assign bus.nREPEN_F  = w_filt[2];
    assign bus.nBOOTEN_F = w_filt[3];
    assign bus.nSWAPEN_F = w_filt[4];
    assign bus.ACC_START = r_start;
    assign bus.ACC_END   = r_end;
    assign bus.ACC_ABORT = r_abort;
    assign bus.ACCMODE   = r_mode;
    assign bus.BUSY      = (r_state == ACCESS);
    assign bus.ACCCNT    = r_cnt;
    assign bus.ERR       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bubble_ctrl_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_bubble_ctrl_frontend
// Brief    : Directed bench with a cycle-level reference model for the
//            Bubble System strobe front end.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bubble_ctrl_frontend;
    localparam int FL = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bubble_ctrl_frontend_if #(.CNT_W(CW)) bus ();

    bubble_ctrl_frontend #(.FILT_LEN(FL), .CNT_W(CW)) dut (
        .MCLK (clk),
        .RST  (rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A filtered strobe flips once the raw level seen 2..FL+1 edges ago has
    // been the opposite level on every one of those FL edges.
    localparam int M_IDLE = 0, M_STBY = 1, M_ACC = 2, M_FAULT = 3;
    logic [15:0]   h [5];
    logic [4:0]    mf, mpf, nf, raw;
    int            ms;
    logic          m_start, m_end, m_abort, m_err;
    logic [2:0]    m_mode;
    logic [CW-1:0] m_cnt;
    logic          flip;

    assign raw = {bus.nSWAPEN, bus.nBOOTEN, bus.nREPEN, bus.nBSEN, bus.nBSS};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 5; s++) h[s] = '1;
            mf = '1; mpf = '1; ms = M_IDLE;
            m_start = 0; m_end = 0; m_abort = 0; m_err = 0;
            m_mode = 3'b000; m_cnt = '0;
        end else begin
            m_start = 0; m_end = 0; m_abort = 0;
            if (ms == M_IDLE) begin
                if (mpf[1] && !mf[1] && mf[0]) begin ms = M_FAULT; m_err = 1; end
                else if (mpf[0] && !mf[0]) ms = M_STBY;
            end else if (ms == M_STBY) begin
                if (!mpf[0] && mf[0]) ms = M_IDLE;
                else if (mpf[1] && !mf[1]) begin
                    ms = M_ACC; m_start = 1;
                    // boot = !nBOOTEN, rep = !nREPEN
                    if (!mf[3] && mf[2])       m_mode = 3'd1;
                    else if (!mf[3] && !mf[2]) m_mode = 3'd2;
                    else if (mf[3] && mf[2])   m_mode = 3'd3;
                    else                       m_mode = 3'd4;
                end
            end else if (ms == M_ACC) begin
                if (!mpf[0] && mf[0]) begin ms = M_IDLE; m_abort = 1; m_err = 1; end
                else if (!mpf[1] && mf[1]) begin ms = M_STBY; m_end = 1; m_cnt = m_cnt + 1'b1; end
            end else begin
                if (mf[1]) ms = mf[0] ? M_IDLE : M_STBY;
            end
            for (int s = 0; s < 5; s++) begin
                flip = 1'b1;
                for (int k = 1; k <= FL; k++) if (h[s][k] == mf[s]) flip = 1'b0;
                nf[s] = flip ? ~mf[s] : mf[s];
            end
            mpf = mf;
            mf  = nf;
            for (int s = 0; s < 5; s++) h[s] = {h[s][14:0], raw[s]};
        end
    end

    // ---------------- per-cycle compare ----------------
    int n_start = 0, n_end = 0, n_abort = 0;
    logic [16:0] exp_v, act_v;

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            exp_v = {mf, m_start, m_end, m_abort, (ms == M_ACC), m_mode, m_cnt, m_err};
            act_v = {bus.nSWAPEN_F, bus.nBOOTEN_F, bus.nREPEN_F, bus.nBSEN_F, bus.nBSS_F,
                     bus.ACC_START, bus.ACC_END, bus.ACC_ABORT, bus.BUSY,
                     bus.ACCMODE, bus.ACCCNT, bus.ERR};
            check("model", 32'(act_v), 32'(exp_v));
            check("pulse_excl", 32'(int'(bus.ACC_START) + int'(bus.ACC_END) + int'(bus.ACC_ABORT) > 1), 32'd0);
            if (bus.ACC_START) n_start++;
            if (bus.ACC_END)   n_end++;
            if (bus.ACC_ABORT) n_abort++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic bss, input logic bsen, input logic rep,
                         input logic boot, input logic swap);
        @(negedge clk);
        bus.nBSS = bss; bus.nBSEN = bsen; bus.nREPEN = rep;
        bus.nBOOTEN = boot; bus.nSWAPEN = swap;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    int s0, e0, a0, first;
    logic [2:0] mode_at;
    logic       busy_at;
    logic       bsen_f_low;

    initial begin
        bus.nBSS = 1; bus.nBSEN = 1; bus.nREPEN = 1; bus.nBOOTEN = 1; bus.nSWAPEN = 1;
        rst = 1;
        cyc(3);
        check("rst_filt", 32'({bus.nSWAPEN_F, bus.nBOOTEN_F, bus.nREPEN_F, bus.nBSEN_F, bus.nBSS_F}), 32'h1f);
        check("rst_pulses", 32'({bus.ACC_START, bus.ACC_END, bus.ACC_ABORT, bus.BUSY}), 32'h0);
        check("rst_mode", 32'(bus.ACCMODE), 32'h0);
        check("rst_cnt", 32'(bus.ACCCNT), 32'h0);
        check("rst_err", 32'(bus.ERR), 32'h0);
        @(negedge clk); rst = 0;

        // 3-cycle glitch on nBSEN while selected
        drive(0, 1, 1, 1, 1); cyc(10);
        s0 = n_start; bsen_f_low = 0;
        drive(0, 0, 1, 1, 1); cyc(2);
        drive(0, 1, 1, 1, 1);
        for (int k = 0; k < 12; k++) begin cyc(1); if (!bus.nBSEN_F) bsen_f_low = 1; end
        check("glitch_bsen_f", 32'(bsen_f_low), 32'd0);
        check("glitch_no_start", 32'(n_start - s0), 32'd0);

        // Boot-loop access: start latency and mode
        drive(0, 1, 1, 0, 1); cyc(8);
        first = 0; mode_at = 3'b000; busy_at = 0;
        drive(0, 0, 1, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #3;
            if (bus.ACC_START && first == 0) begin first = k; mode_at = bus.ACCMODE; busy_at = bus.BUSY; end
        end
        check("start_latency", 32'(first), 32'd7);
        check("start_mode", 32'(mode_at), 32'h1);
        check("start_busy", 32'(busy_at), 32'h1);
        e0 = n_end;
        drive(0, 1, 1, 0, 1); cyc(10);
        check("end_pulse", 32'(n_end - e0), 32'd1);
        check("end_cnt", 32'(bus.ACCCNT), 32'd1);
        check("end_busy", 32'(bus.BUSY), 32'd0);
        check("end_err", 32'(bus.ERR), 32'd0);

        // Protocol error: nBSEN without nBSS
        drive(1, 1, 1, 1, 1); cyc(10);
        s0 = n_start;
        drive(1, 0, 1, 1, 1); cyc(10);
        check("fault_err", 32'(bus.ERR), 32'd1);
        check("fault_no_start", 32'(n_start - s0), 32'd0);
        drive(1, 1, 1, 1, 1); cyc(10);
        drive(0, 1, 1, 1, 1); cyc(10);
        drive(0, 0, 1, 1, 1); cyc(10);
        check("fault_recover", 32'(n_start - s0), 32'd1);
        check("fault_recover_mode", 32'(bus.ACCMODE), 32'h3);

        // Reset mid-access drops BUSY at once
        @(negedge clk); rst = 1; #1;
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_err2", 32'(bus.ERR), 32'd0);
        bus.nBSS = 1; bus.nBSEN = 1;
        cyc(3); @(negedge clk); rst = 0;

        // Abort by releasing nBSS mid-access
        drive(0, 1, 0, 0, 1); cyc(10);
        drive(0, 0, 0, 0, 1); cyc(10);
        check("abort_pre_busy", 32'(bus.BUSY), 32'd1);
        check("abort_pre_mode", 32'(bus.ACCMODE), 32'h2);
        a0 = n_abort; e0 = n_end;
        drive(1, 0, 0, 0, 1); cyc(10);
        check("abort_pulse", 32'(n_abort - a0), 32'd1);
        check("abort_no_end", 32'(n_end - e0), 32'd0);
        check("abort_err", 32'(bus.ERR), 32'd1);
        check("abort_busy", 32'(bus.BUSY), 32'd0);
        check("abort_cnt", 32'(bus.ACCCNT), 32'd0);
        drive(1, 1, 1, 1, 1); cyc(10);

        // Counter wrap with replicated page accesses
        @(negedge clk); rst = 1; cyc(2); @(negedge clk); rst = 0;
        drive(0, 1, 0, 1, 1); cyc(10);
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1, logic'(i[0])); cyc(8);
            check("wrap_mode", 32'(bus.ACCMODE), 32'h4);
            drive(0, 1, 0, 1, logic'(i[0])); cyc(8);
            check("wrap_cnt", 32'(bus.ACCCNT), 32'((i + 1) % 16));
        end
        check("wrap_err", 32'(bus.ERR), 32'd0);
        drive(1, 1, 1, 1, 1); cyc(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bubble_ctrl_frontend.md
# bubble_ctrl_frontend

Conditions the asynchronous Bubble System control strobes (nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN) before they reach TimingGenerator. It synchronises and glitch-filters each strobe, tracks the host access sequence with a small state machine, and classifies each access. It emits start/end/abort pulses, a latched access mode, a completed-access counter and a sticky protocol-error flag. It sits between the board input pins and TimingGenerator in the top level.

## Interface
- FILT_LEN, 4: consecutive MCLK cycles a synchronised input must hold a new level before the filtered output follows; legal range 1..15.
- CNT_W, 16: width of ACCCNT.

- MCLK  in  1  48 MHz master clock; everything is on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- nBSS, nBSEN, nREPEN, nBOOTEN, nSWAPEN  in  1 each  raw asynchronous host strobes, active-low.
- nBSS_F, nBSEN_F, nREPEN_F, nBOOTEN_F, nSWAPEN_F  out  1 each  filtered strobes, registered.
- ACC_START  out  1  one-cycle pulse when a valid access begins.
- ACC_END  out  1  one-cycle pulse when an access completes normally.
- ACC_ABORT  out  1  one-cycle pulse when an access is killed by nBSS_F rising.
- ACCMODE  out  3  access class, latched on entry to ACCESS.
- BUSY  out  1  high while the FSM is in ACCESS.
- ACCCNT  out  CNT_W  count of normally completed accesses; wraps modulo 2^CNT_W.
- ERR  out  1  sticky protocol error; cleared only by RST.

## Operation
- Per strobe: a 2-FF synchroniser, then a filter.
  - Filter counter cnt (4 bits) is cleared whenever sync == filt.
  - When sync != filt, cnt increments.
  - When cnt == FILT_LEN-1 and sync != filt, filt takes sync and cnt clears.
- FSM states:
  - IDLE: nBSS_F=1.
  - STANDBY: nBSS_F=0, nBSEN_F=1.
  - ACCESS.
  - FAULT.
- FSM transitions:
  - IDLE→STANDBY on nBSS_F falling.
  - IDLE→FAULT if nBSEN_F falls while nBSS_F=1. Sets ERR; no ACC_START.
  - STANDBY→ACCESS on nBSEN_F falling. Pulse ACC_START, latch ACCMODE, BUSY=1.
  - STANDBY→IDLE on nBSS_F rising.
  - ACCESS→STANDBY on nBSEN_F rising with nBSS_F=0. Pulse ACC_END, ACCCNT+1.
  - ACCESS→IDLE when nBSS_F rises, including in the same cycle as nBSEN_F rising. Pulse ACC_ABORT and set ERR. No ACC_END; ACCCNT unchanged.
  - FAULT→IDLE once nBSEN_F=1 and nBSS_F=1.
  - FAULT→STANDBY once nBSEN_F=1 and nBSS_F=0.
- ACCMODE, from nBOOTEN_F and nREPEN_F sampled in the cycle nBSEN_F falls:
  - 3'b001 boot loop: nBOOTEN=0, nREPEN=1.
  - 3'b010 boot loop, replicated: both 0.
  - 3'b011 page: both 1.
  - 3'b100 page, replicated: nBOOTEN=1, nREPEN=0.
  - ACCMODE holds its value until the next ACC_START.
- nSWAPEN_F is filtered and passed through only. It has no FSM effect.

## Timing
- Reset values:
  - All filtered outputs and synchroniser flops 1.
  - Filter counters 0.
  - ACC_START, ACC_END, ACC_ABORT, BUSY, ERR all 0.
  - ACCMODE 3'b000, ACCCNT 0, FSM in IDLE.
- RST asserted mid-access drops BUSY immediately. No pulses are issued.
- Raw→filtered latency: 2+FILT_LEN MCLK edges.
- Filtered→pulse latency: 1 edge. The pulse, BUSY change, ACCMODE update and ACCCNT update all land on the same edge.
- Glitch rejection: a raw pulse held for fewer than FILT_LEN synchronised cycles never reaches the filtered output.
- Pulses are exactly 1 cycle and mutually exclusive.
- ACCCNT rolls from 2^CNT_W-1 to 0 without setting ERR.

## Structure
- Package bubble_ctrl_pkg holds:
  - FSM state enum {IDLE, STANDBY, ACCESS, FAULT}.
  - ACCMODE constants MODE_NONE, MODE_BOOT, MODE_BOOT_REP, MODE_PAGE, MODE_PAGE_REP.
- Sub-module sig_filter (synchroniser + filter, parameter FILT_LEN) is instantiated five times.
- FSM, classifier and counter live in the top of this block.

## Test plan
- Reset, FILT_LEN=4 -> all filtered outputs 1, pulses 0, ACCMODE=000, ACCCNT=0, ERR=0.
- 3-cycle low glitch on nBSEN with nBSS=0 -> nBSEN_F stays 1, no ACC_START.
- nBSS low, then nBSEN low with nBOOTEN=0, nREPEN=1:
  - ACC_START 7 edges after the raw nBSEN edge (2 sync + 4 filter + 1), with ACCMODE=001 and BUSY=1.
  - On nBSEN release: ACC_END, ACCCNT=1.
- nBSS raised during ACCESS -> ACC_ABORT, ERR=1, BUSY=0, ACCCNT unchanged, FSM in IDLE.
- nBSEN low while nBSS high -> ERR=1, no ACC_START; after both strobes are released the FSM is back in IDLE.
- CNT_W=4, 16 normal page accesses (nBOOTEN=1, nREPEN=0) -> ACCMODE=100 each time, ACCCNT wraps 15→0, ERR stays 0.
